// File: rtl/saida_serial_arbitro_if.sv
// saida_serial_arbitro_if
// Bundles the request, data and TX handshake signals of the serial arbiter.
// "master" is the side that posts measurements and plays the TX.
// "slave" is the arbiter itself.
interface saida_serial_arbitro_if;
    logic        req_a;
    logic [11:0] dados_a;
    logic        req_b;
    logic [11:0] dados_b;
    logic        serial_enviado;
    logic        partida;
    logic [6:0]  dados_ascii;
    logic        ocupado;
    logic        pronto_a;
    logic        pronto_b;
    logic [3:0]  db_estado;

    modport master (
        output req_a, dados_a, req_b, dados_b, serial_enviado,
        input  partida, dados_ascii, ocupado, pronto_a, pronto_b, db_estado
    );

    modport slave (
        input  req_a, dados_a, req_b, dados_b, serial_enviado,
        output partida, dados_ascii, ocupado, pronto_a, pronto_b, db_estado
    );
endinterface

// File: rtl/saida_serial_arbitro.sv
// saida_serial_arbitro
// Round-robin sharing of one serial TX between measurement sources A and B.
// Each grant sends one ASCII message: [ID] hundreds tens units '#'.
// Define SAIDA_SERIAL_ID_EN to prefix each message with 'A' or 'B'.
module saida_serial_arbitro (
    input  logic                 clock,
    input  logic                 reset,
    saida_serial_arbitro_if.slave bus
);

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        CONCEDE = 4'd1,
        PARTIDA = 4'd2,
        ESPERA  = 4'd3,
        PROXIMO = 4'd4,
        FIM     = 4'd5
    } estado_t;

    localparam logic FONTE_A = 1'b0;
    localparam logic FONTE_B = 1'b1;

`ifdef SAIDA_SERIAL_ID_EN
    localparam logic [2:0] ULTIMO_IDX = 3'd4;
`else
    localparam logic [2:0] ULTIMO_IDX = 3'd3;
`endif

    estado_t     estado_q, estado_d;
    logic        pend_a_q, pend_a_d;
    logic        pend_b_q, pend_b_d;
    logic [11:0] buf_a_q, buf_a_d;
    logic [11:0] buf_b_q, buf_b_d;
    logic [11:0] msg_q, msg_d;
    logic        atual_q, atual_d;
    logic        ultimo_q, ultimo_d;
    logic [2:0]  idx_q, idx_d;
    logic [6:0]  caractere_d;

    logic        partida_q;
    logic [6:0]  ascii_q;
    logic        ocupado_q;
    logic        pronto_a_q;
    logic        pronto_b_q;

    function automatic logic [6:0] digitoAscii(input logic [3:0] d);
        return (d <= 4'd9) ? (7'h30 + {3'b000, d}) : 7'h3F;
    endfunction

    // Next-state logic: arbitration, message sequencing and request capture
    always_comb begin
        estado_d = estado_q;
        pend_a_d = pend_a_q;
        pend_b_d = pend_b_q;
        buf_a_d  = buf_a_q;
        buf_b_d  = buf_b_q;
        msg_d    = msg_q;
        atual_d  = atual_q;
        ultimo_d = ultimo_q;
        idx_d    = idx_q;

        case (estado_q)
            INICIAL: begin
                if (pend_a_q && (!pend_b_q || (ultimo_q == FONTE_B))) begin
                    atual_d  = FONTE_A;
                    estado_d = CONCEDE;
                end else if (pend_b_q) begin
                    atual_d  = FONTE_B;
                    estado_d = CONCEDE;
                end
            end
            CONCEDE: begin
                if (atual_q == FONTE_A) begin
                    msg_d    = buf_a_q;
                    pend_a_d = 1'b0;
                end else begin
                    msg_d    = buf_b_q;
                    pend_b_d = 1'b0;
                end
                ultimo_d = atual_q;
                idx_d    = 3'd0;
                estado_d = PARTIDA;
            end
            PARTIDA: estado_d = ESPERA;
            ESPERA: begin
                if (bus.serial_enviado) begin
                    estado_d = (idx_q == ULTIMO_IDX) ? FIM : PROXIMO;
                end
            end
            PROXIMO: begin
                idx_d    = idx_q + 3'd1;
                estado_d = PARTIDA;
            end
            FIM:     estado_d = INICIAL;
            default: estado_d = INICIAL;
        endcase

        if (bus.req_a) begin
            pend_a_d = 1'b1;
            buf_a_d  = bus.dados_a;
        end
        if (bus.req_b) begin
            pend_b_d = 1'b1;
            buf_b_d  = bus.dados_b;
        end
    end

    // Character selected by the upcoming message register and index
    always_comb begin
        caractere_d = 7'h00;
`ifdef SAIDA_SERIAL_ID_EN
        case (idx_d)
            3'd0:    caractere_d = (atual_d == FONTE_B) ? 7'h42 : 7'h41;
            3'd1:    caractere_d = digitoAscii(msg_d[11:8]);
            3'd2:    caractere_d = digitoAscii(msg_d[7:4]);
            3'd3:    caractere_d = digitoAscii(msg_d[3:0]);
            3'd4:    caractere_d = 7'h23;
            default: caractere_d = 7'h00;
        endcase
`else
        case (idx_d)
            3'd0:    caractere_d = digitoAscii(msg_d[11:8]);
            3'd1:    caractere_d = digitoAscii(msg_d[7:4]);
            3'd2:    caractere_d = digitoAscii(msg_d[3:0]);
            3'd3:    caractere_d = 7'h23;
            default: caractere_d = 7'h00;
        endcase
`endif
    end

    // State register with outputs registered from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIAL;
            pend_a_q   <= 1'b0;
            pend_b_q   <= 1'b0;
            buf_a_q    <= 12'h000;
            buf_b_q    <= 12'h000;
            msg_q      <= 12'h000;
            atual_q    <= FONTE_A;
            ultimo_q   <= FONTE_B;
            idx_q      <= 3'd0;
            partida_q  <= 1'b0;
            ascii_q    <= 7'h00;
            ocupado_q  <= 1'b0;
            pronto_a_q <= 1'b0;
            pronto_b_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            pend_a_q   <= pend_a_d;
            pend_b_q   <= pend_b_d;
            buf_a_q    <= buf_a_d;
            buf_b_q    <= buf_b_d;
            msg_q      <= msg_d;
            atual_q    <= atual_d;
            ultimo_q   <= ultimo_d;
            idx_q      <= idx_d;
            partida_q  <= (estado_d == PARTIDA);
            ascii_q    <= ((estado_d == PARTIDA) || (estado_d == ESPERA)) ? caractere_d : 7'h00;
            ocupado_q  <= (estado_d != INICIAL);
            pronto_a_q <= (estado_d == FIM) && (atual_d == FONTE_A);
            pronto_b_q <= (estado_d == FIM) && (atual_d == FONTE_B);
        end
    end

    assign bus.partida     = partida_q;
    assign bus.dados_ascii = ascii_q;
    assign bus.ocupado     = ocupado_q;
    assign bus.pronto_a    = pronto_a_q;
    assign bus.pronto_b    = pronto_b_q;
    assign bus.db_estado   = estado_q;

endmodule

// File: tb/tb_saida_serial_arbitro.sv
// tb_saida_serial_arbitro
// Directed bench for the serial arbiter; the bench plays the TX side.
// Expected characters follow SAIDA_SERIAL_ID_EN when it is defined.
module tb_saida_serial_arbitro;

    localparam logic FONTE_A = 1'b0;
    localparam logic FONTE_B = 1'b1;

`ifdef SAIDA_SERIAL_ID_EN
    localparam int ID_OFFSET = 1;
`else
    localparam int ID_OFFSET = 0;
`endif
    localparam int NCHARS = 4 + ID_OFFSET;

    logic clock;
    logic reset;
    int   testsRun;
    int   testsFailed;

    saida_serial_arbitro_if bus ();

    saida_serial_arbitro dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [6:0] asciiDigito(input logic [3:0] d);
        if (d > 4'd9) return 7'h3F;
        return 7'h30 + {3'b000, d};
    endfunction

    function automatic logic [6:0] esperado(input logic fonte, input logic [11:0] v, input int c);
        if (c < ID_OFFSET) return (fonte == FONTE_B) ? 7'h42 : 7'h41;
        case (c - ID_OFFSET)
            0:       return asciiDigito(v[11:8]);
            1:       return asciiDigito(v[7:4]);
            2:       return asciiDigito(v[3:0]);
            default: return 7'h23;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one request cycle from the current negedge and returns on the next one
    task automatic applyStimulus(input logic ra, input logic [11:0] da, input logic rb, input logic [11:0] db);
        bus.req_a   = ra;
        bus.dados_a = da;
        bus.req_b   = rb;
        bus.dados_b = db;
        @(negedge clock);
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
    endtask

    task automatic waitPartida(input string tag, output int lat);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            lat++;
            if (bus.partida) seen = 1'b1;
        end
        checkOutput({tag, " partida seen"}, 32'(seen), 32'd1);
    endtask

    // Acts as the TX for one character, answering serial_enviado k cycles after partida
    task automatic serveChar(input string tag, input logic [6:0] expChar, input int k,
                             input logic glitch, input logic sideB, input logic [11:0] sideDados,
                             output int lat);
        waitPartida(tag, lat);
        checkOutput({tag, " ascii"}, 32'(bus.dados_ascii), 32'(expChar));
        checkOutput({tag, " ocupado"}, 32'(bus.ocupado), 32'd1);
        if (glitch) bus.serial_enviado = 1'b1;
        for (int i = 0; i < k; i++) begin
            @(negedge clock);
            bus.serial_enviado = 1'b0;
            if (sideB) begin
                bus.req_b   = (i == 0);
                bus.dados_b = sideDados;
            end
            if (i == 0) begin
                checkOutput({tag, " ascii held"}, 32'(bus.dados_ascii), 32'(expChar));
                checkOutput({tag, " partida single"}, 32'(bus.partida), 32'd0);
                if (glitch) checkOutput({tag, " enviado in PARTIDA ignored"}, 32'(bus.db_estado), 32'd3);
            end
        end
        if (sideB) bus.req_b = 1'b0;
        bus.serial_enviado = 1'b1;
        @(negedge clock);
        bus.serial_enviado = 1'b0;
    endtask

    // Serves a whole message; caller stands on the negedge two cycles before the first partida
    task automatic runMessage(input string tag, input logic fonte, input logic [11:0] valor, input int k,
                              input logic glitch, input logic sideB,
                              input logic [11:0] side1, input logic [11:0] side2);
        int lat;
        for (int c = 0; c < NCHARS; c++) begin
            serveChar($sformatf("%s char%0d", tag, c), esperado(fonte, valor, c), k,
                      glitch && (c == 0), sideB && (c < 2), (c == 0) ? side1 : side2, lat);
            checkOutput($sformatf("%s char%0d latency", tag, c), 32'(lat), (c == 0) ? 32'd2 : 32'd1);
        end
        checkOutput({tag, " pronto_a"}, 32'(bus.pronto_a), 32'(fonte == FONTE_A));
        checkOutput({tag, " pronto_b"}, 32'(bus.pronto_b), 32'(fonte == FONTE_B));
        checkOutput({tag, " ocupado in FIM"}, 32'(bus.ocupado), 32'd1);
        @(negedge clock);
        checkOutput({tag, " pronto_a after"}, 32'(bus.pronto_a), 32'd0);
        checkOutput({tag, " pronto_b after"}, 32'(bus.pronto_b), 32'd0);
        checkOutput({tag, " ocupado after"}, 32'(bus.ocupado), 32'd0);
    endtask

    // Watches n cycles for any partida or pronto activity
    task automatic expectQuiet(input string tag, input int n);
        logic activity;
        activity = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (bus.partida || bus.pronto_a || bus.pronto_b || bus.ocupado) activity = 1'b1;
        end
        checkOutput({tag, " quiet"}, 32'(activity), 32'd0);
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Directed sequence
    initial begin
        int lat;
        testsRun           = 0;
        testsFailed        = 0;
        reset              = 1'b1;
        bus.req_a          = 1'b0;
        bus.dados_a        = 12'h000;
        bus.req_b          = 1'b0;
        bus.dados_b        = 12'h000;
        bus.serial_enviado = 1'b0;

        repeat (3) @(negedge clock);
        checkOutput("reset partida", 32'(bus.partida), 32'd0);
        checkOutput("reset ocupado", 32'(bus.ocupado), 32'd0);
        checkOutput("reset pronto_a", 32'(bus.pronto_a), 32'd0);
        checkOutput("reset pronto_b", 32'(bus.pronto_b), 32'd0);
        checkOutput("reset ascii", 32'(bus.dados_ascii), 32'd0);
        checkOutput("reset db_estado", 32'(bus.db_estado), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Stray serial_enviado while idle
        bus.serial_enviado = 1'b1;
        @(negedge clock);
        bus.serial_enviado = 1'b0;
        checkOutput("idle enviado db_estado", 32'(bus.db_estado), 32'd0);
        checkOutput("idle enviado partida", 32'(bus.partida), 32'd0);

        // Single request from A
        applyStimulus(1'b1, 12'h123, 1'b0, 12'h000);
        runMessage("single A", FONTE_A, 12'h123, 2, 1'b0, 1'b0, 12'h000, 12'h000);
        expectQuiet("single A", 4);

        // Simultaneous requests right after reset: A first
        doReset(2);
        applyStimulus(1'b1, 12'h045, 1'b1, 12'h678);
        runMessage("simul A", FONTE_A, 12'h045, 1, 1'b0, 1'b0, 12'h000, 12'h000);
        runMessage("simul B", FONTE_B, 12'h678, 3, 1'b0, 1'b0, 12'h000, 12'h000);
        expectQuiet("simul", 4);

        // Both sources hold their request: grants alternate
        doReset(2);
        bus.req_a   = 1'b1;
        bus.dados_a = 12'h246;
        bus.req_b   = 1'b1;
        bus.dados_b = 12'h802;
        @(negedge clock);
        runMessage("alt 1 A", FONTE_A, 12'h246, 1, 1'b0, 1'b0, 12'h000, 12'h000);
        runMessage("alt 2 B", FONTE_B, 12'h802, 1, 1'b0, 1'b0, 12'h000, 12'h000);
        runMessage("alt 3 A", FONTE_A, 12'h246, 2, 1'b0, 1'b0, 12'h000, 12'h000);
        runMessage("alt 4 B", FONTE_B, 12'h802, 2, 1'b0, 1'b0, 12'h000, 12'h000);
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        doReset(2);

        // B posts twice during A's message; only the latest value is sent once
        applyStimulus(1'b1, 12'h555, 1'b0, 12'h000);
        runMessage("ovw A", FONTE_A, 12'h555, 3, 1'b0, 1'b1, 12'h111, 12'h999);
        runMessage("ovw B", FONTE_B, 12'h999, 2, 1'b0, 1'b0, 12'h000, 12'h000);
        expectQuiet("ovw", 8);

        // Non-BCD digits, with serial_enviado injected during PARTIDA
        applyStimulus(1'b1, 12'hA0F, 1'b0, 12'h000);
        runMessage("nbcd A", FONTE_A, 12'hA0F, 2, 1'b1, 1'b0, 12'h000, 12'h000);
        expectQuiet("nbcd", 4);

        // Reset during the ESPERA of the tens digit, with B pending
        applyStimulus(1'b1, 12'h789, 1'b0, 12'h000);
        for (int c = 0; c <= ID_OFFSET; c++) begin
            serveChar($sformatf("rst char%0d", c), esperado(FONTE_A, 12'h789, c), 3,
                      1'b0, (c == 0), 12'h321, lat);
        end
        waitPartida("rst tens", lat);
        checkOutput("rst tens ascii", 32'(bus.dados_ascii), 32'h38);
        @(negedge clock);
        checkOutput("rst tens in ESPERA", 32'(bus.db_estado), 32'd3);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("rst partida", 32'(bus.partida), 32'd0);
        checkOutput("rst ocupado", 32'(bus.ocupado), 32'd0);
        checkOutput("rst db_estado", 32'(bus.db_estado), 32'd0);
        checkOutput("rst ascii", 32'(bus.dados_ascii), 32'd0);
        bus.serial_enviado = 1'b1;
        @(negedge clock);
        bus.serial_enviado = 1'b0;
        expectQuiet("rst", 12);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
